// File: rtl/tsn_sched_pkg.sv
// Shared definitions for the strict-priority egress scheduler.
//   state_t     : scheduler FSM encoding (2 bits)
//   clog2_min1  : ceil(log2(n)) clamped to at least 1, used for index/counter widths
package tsn_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Width needed to index n items (or hold values 0..n-1), never less than 1.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = (n <= 1) ? 1 : $clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

endpackage : tsn_sched_pkg

// File: rtl/tsn_sp_arbiter.sv
// Combinational MSB-first priority encoder.
//   req : request vector, bit N-1 is the highest priority
//   idx : index of the highest set request bit (0 when none set)
//   any : at least one request bit is set
module tsn_sp_arbiter
    import tsn_sched_pkg::*;
#(
    parameter int unsigned N     = 8,
    localparam int unsigned PRI_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    output logic [PRI_W-1:0] idx,
    output logic             any
);

    // Ascending scan: the last set bit seen (the highest) wins.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = PRI_W'(i);
            end
        end
    end

    assign any = |req;

endmodule : tsn_sp_arbiter

// File: rtl/tsn_qos_sp_sched.sv
// Strict-priority transmit scheduler for one egress port.
// Masks per-queue occupancy with the Qbv gate vector, grants the highest
// eligible queue to the TX MAC reader, holds the grant for the whole frame and
// then enforces an inter-frame gap before arbitrating again.
//   i_clk / i_rst        : clock, synchronous active-high reset
//   i_ControlList_state  : per-priority gate state, 1 = open
//   i_fifo_empty         : per-priority queue empty flag, 1 = empty
//   o_sched_vld / o_sched_pri / i_sched_ack : grant handshake to the reader
//   i_tx_done            : one-cycle pulse, granted frame fully read out
//   o_busy               : high from grant until the gap has expired
module tsn_qos_sp_sched
    import tsn_sched_pkg::*;
#(
    parameter int unsigned PORT_FIFO_PRI_NUM = 8,
    parameter int unsigned IFG_CYCLES        = 3,
    localparam int unsigned PRI_W            = clog2_min1(PORT_FIFO_PRI_NUM)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [PORT_FIFO_PRI_NUM-1:0] i_ControlList_state,
    input  logic [PORT_FIFO_PRI_NUM-1:0] i_fifo_empty,
    output logic                         o_sched_vld,
    output logic [PRI_W-1:0]             o_sched_pri,
    input  logic                         i_sched_ack,
    input  logic                         i_tx_done,
    output logic                         o_busy
);

    localparam int unsigned CNT_W = clog2_min1(IFG_CYCLES + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD =
        CNT_W'((IFG_CYCLES == 0) ? 0 : (IFG_CYCLES - 1));

    state_t             state_q, state_d;
    logic               vld_q, vld_d;
    logic [PRI_W-1:0]   pri_q, pri_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PORT_FIFO_PRI_NUM-1:0] eligible;
    logic [PRI_W-1:0]             win_idx;
    logic                         win_any;

    // Eligibility is evaluated fresh every cycle, never registered.
    assign eligible = i_ControlList_state & ~i_fifo_empty;

    tsn_sp_arbiter #(
        .N   (PORT_FIFO_PRI_NUM)
    ) u_arb (
        .req (eligible),
        .idx (win_idx),
        .any (win_any)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        pri_d   = pri_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    pri_d   = win_idx;
                    vld_d   = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Ack has precedence over a same-cycle gate close.
                if (i_sched_ack) begin
                    vld_d   = 1'b0;
                    state_d = ST_BUSY;
                end else if (!i_ControlList_state[pri_q]) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Gate changes are ignored mid-frame; guard band is upstream.
                if (i_tx_done) begin
                    if (IFG_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
            pri_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            pri_q   <= pri_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_sched_vld = vld_q;
    assign o_sched_pri = pri_q;
    assign o_busy      = busy_q;

endmodule : tsn_qos_sp_sched

// File: tb/tb_tsn_qos_sp_sched.sv
// Self-checking bench for tsn_qos_sp_sched: directed scenarios followed by
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_tsn_qos_sp_sched;

    localparam int unsigned N   = 8;
    localparam int unsigned IFG = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] gate;
    logic [N-1:0] empty;
    logic         vld;
    logic [2:0]   pri;
    logic         ack;
    logic         done;
    logic         busy;

    int total = 0;
    int bad   = 0;

    // Model: outstanding grant, frame in flight, remaining gap cycles.
    bit m_vld;
    int m_pri;
    bit m_frame;
    int m_gap;

    always #2 clk = ~clk;

    tsn_qos_sp_sched #(
        .PORT_FIFO_PRI_NUM (N),
        .IFG_CYCLES        (IFG)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_ControlList_state (gate),
        .i_fifo_empty        (empty),
        .o_sched_vld         (vld),
        .o_sched_pri         (pri),
        .i_sched_ack         (ack),
        .i_tx_done           (done),
        .o_busy              (busy)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    function automatic void model_step();
        int best;
        if (rst) begin
            m_vld = 0; m_pri = 0; m_frame = 0; m_gap = 0;
        end else if (m_vld) begin
            if (ack) begin
                m_vld = 0; m_frame = 1;
            end else if (!gate[m_pri]) begin
                m_vld = 0;
            end
        end else if (m_frame) begin
            if (done) begin
                m_frame = 0; m_gap = IFG;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            best = -1;
            for (int i = 0; i < N; i++)
                if (gate[i] && !empty[i]) best = i;
            if (best >= 0) begin
                m_vld = 1; m_pri = best;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("vld", int'(vld), int'(m_vld));
        check_eq("busy", int'(busy), int'(m_vld || m_frame || m_gap > 0));
        check_eq("pri", int'(pri), m_pri);
    endtask

    // Accept the current grant, finish the frame, and let the gap expire.
    task automatic finish_frame();
        int n;
        ack = 1'b1; tick(); ack = 1'b0;
        done = 1'b1; tick(); done = 1'b0;
        n = 0;
        while (busy && n < 20) begin tick(); n++; end
        check_eq("gap_bound", int'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; gate = 8'hFF; empty = 8'hFF; ack = 1'b0; done = 1'b0;
        m_vld = 0; m_pri = 0; m_frame = 0; m_gap = 0;
        tick(); tick();
        check_eq("rst_vld", int'(vld), 0);
        check_eq("rst_pri", int'(pri), 0);
        check_eq("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // 1: nothing eligible
        repeat (10) tick();
        check_eq("t1_vld", int'(vld), 0);
        check_eq("t1_busy", int'(busy), 0);

        // 2: q7 then q5 with a 3-cycle gap in between
        empty = 8'b0101_1111;
        tick();
        check_eq("t2_vld", int'(vld), 1);
        check_eq("t2_pri7", int'(pri), 7);
        ack = 1'b1; tick(); ack = 1'b0;
        check_eq("t2_ack_vld", int'(vld), 0);
        check_eq("t2_ack_busy", int'(busy), 1);
        empty = 8'b1101_1111;
        done = 1'b1; tick(); done = 1'b0;
        check_eq("t2_gap1", int'(busy), 1);
        tick(); check_eq("t2_gap2", int'(busy), 1);
        tick(); check_eq("t2_gap3", int'(busy), 1);
        tick(); check_eq("t2_idle", int'(busy), 0);
        check_eq("t2_idle_vld", int'(vld), 0);
        tick();
        check_eq("t2_vld5", int'(vld), 1);
        check_eq("t2_pri5", int'(pri), 5);
        finish_frame();

        // 3: only low gates open
        gate = 8'h0F; empty = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("t3_vld", int'(vld), 1);
            check_eq("t3_pri3", int'(pri), 3);
            finish_frame();
        end

        // 4: revocation, then ack racing gate close
        gate = 8'hFF;
        tick();
        check_eq("t4_pri7", int'(pri), 7);
        gate = 8'h7F; tick();
        check_eq("t4_revoke_vld", int'(vld), 0);
        check_eq("t4_revoke_busy", int'(busy), 0);
        gate = 8'hFF; tick();
        check_eq("t4_regrant", int'(vld), 1);
        gate = 8'h7F; ack = 1'b1; tick(); ack = 1'b0;
        check_eq("t4_race_vld", int'(vld), 0);
        check_eq("t4_race_busy", int'(busy), 1);

        // 5: gates close mid-frame, no grant until done + IFG and reopen
        gate = 8'h00; empty = 8'h00;
        repeat (5) tick();
        check_eq("t5_hold_busy", int'(busy), 1);
        done = 1'b1; tick(); done = 1'b0;
        repeat (6) tick();
        check_eq("t5_closed_vld", int'(vld), 0);
        gate = 8'h80; tick();
        check_eq("t5_reopen_vld", int'(vld), 1);
        check_eq("t5_reopen_pri", int'(pri), 7);

        // 6: reset in BUSY and in GAP, spurious strobes in IDLE
        ack = 1'b1; tick(); ack = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("t6_busy_rst", int'(busy), 0);
        check_eq("t6_busy_rst_pri", int'(pri), 0);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        done = 1'b1; tick(); done = 1'b0;
        check_eq("t6_in_gap", int'(busy), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("t6_gap_rst", int'(busy), 0);
        check_eq("t6_gap_rst_vld", int'(vld), 0);
        gate = 8'h00; ack = 1'b1; done = 1'b1;
        repeat (3) tick();
        ack = 1'b0; done = 1'b0;
        check_eq("t6_spurious", int'(busy), 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) gate = N'($urandom);
            if ($urandom_range(0, 3) == 0) empty = N'($urandom);
            ack  = m_vld ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            done = m_frame ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 15) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; ack = 1'b0; done = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tsn_qos_sp_sched
